// File: rtl/hamming_chunk_feeder.sv
// hamming_chunk_feeder
// Upstream stage of the sequential Hamming-distance accumulator. Accepts the
// two operands as IN_W-bit word pairs over a valid/ready stream and hands the
// accumulator one CHUNK-bit slice of each operand per cycle, LSB first.
// x and y are forced to zero whenever no real slice is present. The
// accumulator has no enable, and XOR of zeros adds nothing to its sum.
module hamming_chunk_feeder #(
    parameter int N     = 1600,
    parameter int CHUNK = 5,
    parameter int IN_W  = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    input  logic [IN_W-1:0]  in_y,
    output logic [CHUNK-1:0] x,
    output logic [CHUNK-1:0] y,
    output logic             chunk_valid,
    output logic             acc_clr,
    output logic             busy,
    output logic             done
);

    // Slices per word and words per frame, plus counter widths sized so that
    // neither counter ever has to wrap inside a frame.
    localparam int SPW   = IN_W / CHUNK;
    localparam int WORDS = N / IN_W;
    localparam int SW    = (SPW   > 1) ? $clog2(SPW)   : 1;
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [SW-1:0] LAST_SLICE = SW'(SPW - 1);
    localparam logic [WW-1:0] LAST_WORD  = WW'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [IN_W-1:0] sx;
    logic [IN_W-1:0] sy;
    logic [SW-1:0]   slice_cnt;
    logic [WW-1:0]   word_cnt;
    logic            last_slice;
    logic            last_word;
    logic            accept;

    assign last_slice = (slice_cnt == LAST_SLICE);
    assign last_word  = (word_cnt == LAST_WORD);
    assign accept     = in_valid && in_ready;

    // State register; an asserted reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and all outputs. The outputs decode only the registered
    // state, so they fall to zero as soon as reset forces IDLE.
    always_comb begin
        next_state  = state;
        in_ready    = 1'b0;
        chunk_valid = 1'b0;
        x           = '0;
        y           = '0;
        acc_clr     = 1'b0;
        done        = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                acc_clr    = 1'b1;
                next_state = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                chunk_valid = 1'b1;
                x           = sx[CHUNK-1:0];
                y           = sy[CHUNK-1:0];
                if (last_slice) begin
                    if (last_word) begin
                        next_state = S_DONE;
                    end else begin
                        // Offer the next word pair during the final slice so
                        // that back-to-back words leave no idle cycle.
                        in_ready   = 1'b1;
                        next_state = in_valid ? S_SHIFT : S_LOAD;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Operand shift registers and the slice/word counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx        <= '0;
            sy        <= '0;
            slice_cnt <= '0;
            word_cnt  <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    slice_cnt <= '0;
                    word_cnt  <= '0;
                end
                S_LOAD: begin
                    if (accept) begin
                        sx        <= in_x;
                        sy        <= in_y;
                        slice_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (last_slice) begin
                        slice_cnt <= '0;
                        if (!last_word) begin
                            word_cnt <= word_cnt + WW'(1);
                        end
                        if (accept) begin
                            sx <= in_x;
                            sy <= in_y;
                        end else begin
                            sx <= sx >> CHUNK;
                            sy <= sy >> CHUNK;
                        end
                    end else begin
                        sx        <= sx >> CHUNK;
                        sy        <= sy >> CHUNK;
                        slice_cnt <= slice_cnt + SW'(1);
                    end
                end
                S_DONE: begin
                    word_cnt <= '0;
                end
                default: begin
                    slice_cnt <= slice_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_chunk_feeder.sv
// tb_hamming_chunk_feeder
// Directed bench for hamming_chunk_feeder. Each accepted word pair queues its
// eight expected slices. A single per-cycle compare process pops that queue
// and tracks the downstream Hamming sum, slice count, acc_clr and done.
module tb_hamming_chunk_feeder;

    localparam int N     = 1600;
    localparam int CHUNK = 5;
    localparam int IN_W  = 40;
    localparam int SPW   = IN_W / CHUNK;
    localparam int WORDS = N / IN_W;
    localparam int CC    = N / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_x = '0;
    logic [IN_W-1:0]  in_y = '0;
    logic [CHUNK-1:0] x;
    logic [CHUNK-1:0] y;
    logic             chunk_valid;
    logic             acc_clr;
    logic             busy;
    logic             done;

    hamming_chunk_feeder #(.N(N), .CHUNK(CHUNK), .IN_W(IN_W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_x(in_x),
        .in_y(in_y),
        .x(x),
        .y(y),
        .chunk_valid(chunk_valid),
        .acc_clr(acc_clr),
        .busy(busy),
        .done(done)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Frame operands and expected-slice queue ({x,y} per slice).
    logic [IN_W-1:0]       fx [WORDS];
    logic [IN_W-1:0]       fy [WORDS];
    logic [2*CHUNK-1:0]    expQ [$];
    logic [CHUNK-1:0]      sliceLog [SPW];
    int sliceCount;
    int dutSum;
    int accClrCount;
    int doneCount;
    int firstCyc;
    int lastCyc;
    int cyc = 0;
    bit checkEn = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic resetStats();
        expQ.delete();
        sliceCount  = 0;
        dutSum      = 0;
        accClrCount = 0;
        doneCount   = 0;
        firstCyc    = 0;
        lastCyc     = -10;
        for (int i = 0; i < SPW; i++) sliceLog[i] = '0;
    endtask

    function automatic int expectedSum();
        int s = 0;
        for (int i = 0; i < WORDS; i++) s += $countones(fx[i] ^ fy[i]);
        return s;
    endfunction

    // Per-cycle compare against the slice queue and frame bookkeeping.
    logic [2*CHUNK-1:0] expSlice;
    bit legal;
    always @(negedge clk) begin
        cyc++;
        if (checkEn) begin
            if (chunk_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("slice_unexpected", 64'd1, 64'd0);
                end else begin
                    expSlice = expQ.pop_front();
                    checkOutput("slice_xy", {x, y}, expSlice);
                end
                if (sliceCount < SPW) sliceLog[sliceCount] = x;
                if (sliceCount == 0) firstCyc = cyc;
                lastCyc = cyc;
                sliceCount++;
                dutSum += $countones(x ^ y);
            end else begin
                checkOutput("idle_xy_zero", {x, y}, 64'd0);
            end
            if (acc_clr) accClrCount++;
            if (done) begin
                doneCount++;
                checkOutput("done_after_last", cyc, lastCyc + 1);
            end
            if (in_ready) begin
                legal = busy && !acc_clr && !done &&
                        (!chunk_valid || ((sliceCount % SPW) == 0 && sliceCount != CC));
                checkOutput("in_ready_legal", legal, 1);
            end
        end
    end

    // Present word w after gap idle cycles and queue its slices on acceptance.
    task automatic sendWord(input int w, input int gap);
        int n = 0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_x     = fx[w];
        in_y     = fy[w];
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            for (int s = 0; s < SPW; s++) begin
                expQ.push_back({5'((fx[w] >> (CHUNK * s)) & 40'h1F),
                                5'((fy[w] >> (CHUNK * s)) & 40'h1F)});
            end
            @(negedge clk);
        end
    endtask

    // Run one full frame and check its totals.
    task automatic applyStimulus(input int gap, input bit glitch, input int expSum,
                                 input string tag);
        int n = 0;
        resetStats();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_acc_clr_t1"}, acc_clr, 1);
        checkOutput({tag, "_in_ready_t1"}, in_ready, 0);
        @(negedge clk);
        checkOutput({tag, "_in_ready_t2"}, in_ready, 1);
        for (int w = 0; w < WORDS; w++) begin
            sendWord(w, gap);
            if (glitch && w == 5) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
        while (doneCount == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done_seen"}, doneCount, 1);
        repeat (2) @(negedge clk);
        checkOutput({tag, "_idle_after"}, busy, 0);
        checkOutput({tag, "_done_once"}, doneCount, 1);
        checkOutput({tag, "_slices"}, sliceCount, CC);
        checkOutput({tag, "_sum"}, dutSum, expSum);
        checkOutput({tag, "_acc_clr_once"}, accClrCount, 1);
        checkOutput({tag, "_queue_empty"}, expQ.size(), 0);
        if (gap == 0) checkOutput({tag, "_contiguous"}, lastCyc - firstCyc, CC - 1);
    endtask

    task automatic fillConst(input logic [IN_W-1:0] vx, input logic [IN_W-1:0] vy);
        for (int i = 0; i < WORDS; i++) begin
            fx[i] = vx;
            fy[i] = vy;
        end
    endtask

    // Test sequence.
    initial begin
        logic [63:0] r;
        resetStats();
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {in_ready, x, y, chunk_valid, acc_clr, busy, done}, 64'd0);
        rst = 1'b1;
        checkEn = 1'b1;
        @(negedge clk);

        $display("[TB] scenario 1: all-ones vs zero");
        fillConst({IN_W{1'b1}}, '0);
        applyStimulus(0, 1'b0, 1600, "s1");

        $display("[TB] scenario 2: equal operands");
        fillConst(40'hA5A5A5A5A5, 40'hA5A5A5A5A5);
        applyStimulus(0, 1'b0, 0, "s2");

        $display("[TB] scenario 3: gaps before each word");
        fillConst({IN_W{1'b1}}, '0);
        applyStimulus(3, 1'b0, 1600, "s3");

        $display("[TB] scenario 4: slice order LSB first");
        for (int i = 0; i < WORDS; i++) begin
            r = {$urandom, $urandom};
            fx[i] = r[IN_W-1:0];
            r = {$urandom, $urandom};
            fy[i] = r[IN_W-1:0];
        end
        fx[0] = 40'h000000001F;
        fy[0] = '0;
        applyStimulus(0, 1'b0, expectedSum(), "s4");
        checkOutput("s4_slice0", sliceLog[0], 5'h1F);
        for (int i = 1; i < SPW; i++) checkOutput("s4_slice_zero", sliceLog[i], 5'h00);

        $display("[TB] scenario 5: reset mid-frame");
        fillConst({IN_W{1'b1}}, '0);
        resetStats();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 13; w++) sendWord(w, 0);
        repeat (4) @(negedge clk);
        #2;
        checkEn = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("s5_async_reset", {in_ready, x, y, chunk_valid, acc_clr, busy, done}, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("s5_idle_after_reset", {busy, done, chunk_valid}, 64'd0);
        applyStimulus(0, 1'b0, 1600, "s5");

        $display("[TB] scenario 6: start during SHIFT ignored");
        applyStimulus(0, 1'b1, 1600, "s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
